// File: rtl/cia_tod_ctrl.sv
// ---------------------------------------------------------------------------
// cia_tod_ctrl -- CIA Time Of Day sequencer
//
// Owns the live TOD time (BCD tenths/sec/min/hr + AM/PM), the alarm
// registers, the read latch and the run/halt state. The 50/60 Hz TOD pin is
// prescaled to tenths of a second, the time counts in BCD and a one-cycle
// ALRM pulse is raised when the live time becomes equal to the alarm.
//
// Ports:
//   clk        core clock
//   res_n      asynchronous active-low reset
//   chip       0 = MOS6526, 1 = MOS8521 (6526 flips AM/PM on a 12 o'clock write)
//   tod_pin    TOD pin, already synchronised to clk
//   todin      1 = 50 Hz pin, 0 = 60 Hz pin
//   alarm_sel  1 = register writes go to the alarm instead of the time
//   we, re     one-cycle register write / read strobes
//   addr       0 = 10ths, 1 = sec, 2 = min, 3 = hr
//   data_i     write data
//   data_o     read data (combinational)
//   alrm       one-cycle alarm pulse to the ICR
//   halted     counter halted (status/debug)
// ---------------------------------------------------------------------------
module cia_tod_ctrl #(
  parameter int PRESCALE_W = 3
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       chip,
  input  logic       tod_pin,
  input  logic       todin,
  input  logic       alarm_sel,
  input  logic       we,
  input  logic       re,
  input  logic [1:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       alrm,
  output logic       halted
);

  localparam logic            CHIP_MOS6526 = 1'b0;
  // Bits that exist in each register byte; everything else reads as zero.
  localparam logic [3:0][7:0] FIELD_MASK   = {8'h9F, 8'h7F, 8'h7F, 8'h0F};

  // Low BCD digit: 9 wraps to 0 with carry, anything else (including
  // invalid digits) counts in plain 4-bit binary. Result is {carry, next}.
  function automatic logic [4:0] step_lo(input logic [3:0] d);
    if (d == 4'd9) step_lo = 5'b1_0000;
    else           step_lo = {1'b0, d + 4'd1};
  endfunction

  // High digit of sec/min: 5 wraps to 0 with carry, else 3-bit binary.
  function automatic logic [3:0] step_hi(input logic [2:0] d);
    if (d == 3'd5) step_hi = 4'b1_000;
    else           step_hi = {1'b0, d + 3'd1};
  endfunction

  // Hour step on a minute carry: returns {pm, hh, hl}.
  function automatic logic [5:0] step_hr(input logic pm, input logic hh,
                                         input logic [3:0] hl);
    if (!hh && hl == 4'd9)     step_hr = {pm, 1'b1, 4'd0};
    else if (hh && hl == 4'd1) step_hr = {~pm, 1'b1, 4'd2};
    else if (hh && hl == 4'd2) step_hr = {pm, 1'b0, 4'd1};
    else                       step_hr = {pm, hh, hl + 4'd1};
  endfunction

  logic [3:0]            ten_t;
  logic [2:0]            sec_sh;
  logic [3:0]            sec_sl;
  logic [2:0]            min_sh;
  logic [3:0]            min_sl;
  logic                  hr_pm;
  logic                  hr_hh;
  logic [3:0]            hr_hl;
  logic [PRESCALE_W-1:0] pre;
  logic                  tod_pin_p1;
  logic                  latched;
  logic                  match_p1;
  logic [3:0][7:0]       alm_b;
  logic [3:0][7:0]       latch_b;
  logic [3:0][7:0]       live_b;

  logic                  tod_edge;
  logic                  tick;
  logic                  time_we;
  logic                  match;
  logic [PRESCALE_W-1:0] limit;
  logic                  c_t, c_sl, c_sh, c_ml, c_mh;
  logic [3:0]            t_inc, sl_inc, ml_inc;
  logic [2:0]            sh_inc, mh_inc;
  logic [5:0]            hr_inc;
  logic                  rip_sh, rip_ml, rip_mh, rip_hr;

  assign live_b = {{hr_pm, 2'b00, hr_hh, hr_hl},
                   {1'b0, min_sh, min_sl},
                   {1'b0, sec_sh, sec_sl},
                   {4'h0, ten_t}};

  assign limit    = todin ? PRESCALE_W'(4) : PRESCALE_W'(5);
  assign tod_edge = tod_pin & ~tod_pin_p1;
  // ">=" so that a todin change with the prescaler already at 5 still ticks.
  assign tick     = tod_edge & ~halted & (pre >= limit);
  assign time_we  = we & ~alarm_sel;
  assign match    = (live_b == alm_b);
  assign data_o   = latched ? latch_b[addr] : live_b[addr];

  assign {c_t,  t_inc}  = step_lo(ten_t);
  assign {c_sl, sl_inc} = step_lo(sec_sl);
  assign {c_sh, sh_inc} = step_hi(sec_sh);
  assign {c_ml, ml_inc} = step_lo(min_sl);
  assign {c_mh, mh_inc} = step_hi(min_sh);
  assign hr_inc         = step_hr(hr_pm, hr_hh, hr_hl);

  assign rip_sh = c_t & c_sl;
  assign rip_ml = rip_sh & c_sh;
  assign rip_mh = rip_ml & c_ml;
  assign rip_hr = rip_mh & c_mh;

  // Stage p0 -> p1: pin edge history, prescaler, run state and live time.
  // A time write wins over a tick in the same cycle; the tick is lost.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tod_pin_p1 <= 1'b0;
      pre        <= '0;
      halted     <= 1'b1;
      ten_t      <= 4'd0;
      sec_sh     <= 3'd0;
      sec_sl     <= 4'd0;
      min_sh     <= 3'd0;
      min_sl     <= 4'd0;
      hr_pm      <= 1'b0;
      hr_hh      <= 1'b0;
      hr_hl      <= 4'd1;
    end else begin
      tod_pin_p1 <= tod_pin;
      if (halted)        pre <= '0;
      else if (tod_edge) pre <= (pre >= limit) ? '0 : pre + PRESCALE_W'(1);
      if (time_we) begin
        case (addr)
          2'd0: begin
            ten_t  <= data_i[3:0];
            halted <= 1'b0;
            pre    <= '0;
          end
          2'd1: begin
            sec_sh <= data_i[6:4];
            sec_sl <= data_i[3:0];
          end
          2'd2: begin
            min_sh <= data_i[6:4];
            min_sl <= data_i[3:0];
          end
          default: begin
            hr_pm  <= (chip == CHIP_MOS6526 && data_i[4:0] == 5'h12) ?
                      ~data_i[7] : data_i[7];
            hr_hh  <= data_i[4];
            hr_hl  <= data_i[3:0];
            halted <= 1'b1;
          end
        endcase
      end else if (tick) begin
        ten_t <= t_inc;
        if (c_t)    sec_sl <= sl_inc;
        if (rip_sh) sec_sh <= sh_inc;
        if (rip_ml) min_sl <= ml_inc;
        if (rip_mh) min_sh <= mh_inc;
        if (rip_hr) {hr_pm, hr_hh, hr_hl} <= hr_inc;
      end
    end
  end

  // Stage p0 -> p1: alarm registers, read-latch flag and alarm edge detect.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      alm_b    <= '0;
      latched  <= 1'b0;
      match_p1 <= 1'b0;
      alrm     <= 1'b0;
    end else begin
      if (we && alarm_sel) alm_b[addr] <= data_i & FIELD_MASK[addr];
      if (re && addr == 2'd3 && !latched) latched <= 1'b1;
      else if (re && addr == 2'd0)        latched <= 1'b0;
      match_p1 <= match;
      alrm     <= match & ~match_p1;
    end
  end

  // Latch contents are only visible while latched is set, which always
  // follows a capture, so they need no reset.
  always_ff @(posedge clk) begin
    if (re && addr == 2'd3 && !latched) latch_b <= live_b;
  end

endmodule

// File: tb/tb_cia_tod_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cia_tod_ctrl -- bench for cia_tod_ctrl
//
// Directed scenarios followed by randomized traffic. A clock-level reference
// model keeps the time as plain integers (hours 1..12 + pm, minutes, seconds,
// tenths) and counts edges/ticks arithmetically; register bytes are derived
// from it by BCD conversion.
// ---------------------------------------------------------------------------
module tb_cia_tod_ctrl;

  logic       clk = 1'b0;
  logic       res_n;
  logic       chip;
  logic       tod_pin;
  logic       todin;
  logic       alarm_sel;
  logic       we;
  logic       re;
  logic [1:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       alrm;
  logic       halted;

  always #5 clk = ~clk;

  cia_tod_ctrl #(.PRESCALE_W(3)) dut (
    .clk      (clk),
    .res_n    (res_n),
    .chip     (chip),
    .tod_pin  (tod_pin),
    .todin    (todin),
    .alarm_sel(alarm_sel),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .data_i   (data_i),
    .data_o   (data_o),
    .alrm     (alrm),
    .halted   (halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_t, m_s, m_m, m_h, m_pre;
  bit         m_pm, m_halt, m_pin_prev, m_latched, m_prev_match, m_alrm;
  logic [7:0] m_latch [4];
  logic [7:0] m_alm   [4];

  logic [7:0] last_dout;
  int         alrm_seen;
  bit         pin_lvl;

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int unbcd(input logic [7:0] d);
    return int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [7:0] field_mask(input int a);
    case (a)
      0:       return 8'h0F;
      1, 2:    return 8'h7F;
      default: return 8'h9F;
    endcase
  endfunction

  function automatic logic [7:0] m_live(input int a);
    case (a)
      0:       return bcd(m_t);
      1:       return bcd(m_s);
      2:       return bcd(m_m);
      default: return bcd(m_h) | (m_pm ? 8'h80 : 8'h00);
    endcase
  endfunction

  task automatic m_reset();
    m_t = 0; m_s = 0; m_m = 0; m_h = 1; m_pm = 1'b0;
    m_halt = 1'b1; m_pre = 0; m_pin_prev = 1'b0; m_latched = 1'b0;
    m_prev_match = 1'b0; m_alrm = 1'b0;
    for (int i = 0; i < 4; i++) m_alm[i] = 8'h00;
  endtask

  // One tenth of a second on a 12-hour clock.
  task automatic m_advance();
    m_t++;
    if (m_t == 10) begin
      m_t = 0; m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin
          m_m = 0;
          if (m_h == 11)      begin m_h = 12; m_pm = !m_pm; end
          else if (m_h == 12) m_h = 1;
          else                m_h++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample data_o mid-cycle, step the model,
  // then check alrm/halted just after the edge.
  task automatic cyc(input bit w, input bit r, input bit asel,
                     input logic [1:0] a, input logic [7:0] d);
    bit match, nxt_alrm, edge_seen, tick;
    int lim;
    we = w; re = r; alarm_sel = asel; addr = a; data_i = d; tod_pin = pin_lvl;
    @(negedge clk);
    last_dout = data_o;
    if (r) chk($sformatf("read_a%0d", a), data_o, m_latched ? m_latch[a] : m_live(a));
    match = 1'b1;
    for (int i = 0; i < 4; i++) if (m_live(i) !== m_alm[i]) match = 1'b0;
    nxt_alrm = match && !m_prev_match;
    m_prev_match = match;
    if (r && a == 2'd3 && !m_latched) begin
      for (int i = 0; i < 4; i++) m_latch[i] = m_live(i);
      m_latched = 1'b1;
    end else if (r && a == 2'd0) m_latched = 1'b0;
    edge_seen = pin_lvl && !m_pin_prev;
    m_pin_prev = pin_lvl;
    lim = todin ? 4 : 5;
    tick = 1'b0;
    if (m_halt) m_pre = 0;
    else if (edge_seen) begin
      if (m_pre >= lim) begin m_pre = 0; tick = 1'b1; end
      else m_pre++;
    end
    if (w && asel) m_alm[a] = d & field_mask(a);
    if (w && !asel) begin
      case (a)
        2'd0: begin m_t = int'(d[3:0]); m_halt = 1'b0; m_pre = 0; end
        2'd1: m_s = unbcd(d & 8'h7F);
        2'd2: m_m = unbcd(d & 8'h7F);
        default: begin
          m_h = unbcd(d & 8'h1F);
          m_pm = d[7] ^ (chip == 1'b0 && d[4:0] == 5'h12);
          m_halt = 1'b1;
        end
      endcase
    end else if (tick) m_advance();
    m_alrm = nxt_alrm;
    @(posedge clk);
    #1;
    if (alrm) alrm_seen++;
    chk("alrm", {7'd0, alrm}, {7'd0, m_alrm});
    chk("halted", {7'd0, halted}, {7'd0, m_halt});
  endtask

  task automatic wr(input bit asel, input logic [1:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, asel, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic pk(input logic [1:0] a);
    cyc(1'b0, 1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      pin_lvl = 1'b1; pk(2'd0);
      pin_lvl = 1'b0; pk(2'd0);
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic [7:0] t);
    wr(1'b0, 2'd3, h); wr(1'b0, 2'd2, m); wr(1'b0, 2'd1, s); wr(1'b0, 2'd0, t);
  endtask

  task automatic do_reset();
    res_n = 1'b0; pin_lvl = 1'b0; tod_pin = 1'b0; we = 1'b0; re = 1'b0;
    #2;
    m_reset();
    res_n = 1'b1;
  endtask

  task automatic rand_cycle();
    bit w, r, asel;
    logic [1:0] a;
    logic [7:0] d;
    if ($urandom_range(0, 2) == 0) pin_lvl = ~pin_lvl;
    chip = 1'($urandom_range(0, 1));
    w    = ($urandom_range(0, 31) == 0);
    r    = ($urandom_range(0, 7) == 0);
    asel = 1'($urandom_range(0, 1));
    a    = 2'($urandom_range(0, 3));
    d    = 8'h00;
    if (w && asel) begin
      d = ($urandom_range(0, 1) == 1) ? m_live(a) : 8'($urandom_range(0, 255));
    end else if (w) begin
      if ($urandom_range(0, 1) == 1) a = 2'd0;
      case (a)
        2'd0:       d = bcd(int'($urandom_range(0, 9)));
        2'd1, 2'd2: d = bcd(int'($urandom_range(0, 59)));
        default:    d = bcd(int'($urandom_range(1, 12))) |
                        (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00);
      endcase
    end
    cyc(w, r, asel, a, d);
  endtask

  initial begin
    res_n = 1'b0; chip = 1'b1; tod_pin = 1'b0; todin = 1'b0; alarm_sel = 1'b0;
    we = 1'b0; re = 1'b0; addr = 2'd0; data_i = 8'h00; pin_lvl = 1'b0;
    alrm_seen = 0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("reset_byte%0d", a), data_o, (a == 3) ? 8'h01 : 8'h00);
    end
    chk("reset_halted", {7'd0, halted}, 8'h01);
    chk("reset_alrm", {7'd0, alrm}, 8'h00);
    @(posedge clk);
    #1;
    res_n = 1'b1;

    // Prescaler: 6 edges at 60 Hz, 5 edges at 50 Hz
    todin = 1'b0;
    wr(1'b0, 2'd0, 8'h00);
    chk("run_after_10ths_write", {7'd0, halted}, 8'h00);
    edges(5); pk(2'd0); chk("60hz_5_edges", last_dout, 8'h00);
    edges(1); pk(2'd0); chk("60hz_6_edges", last_dout, 8'h01);
    todin = 1'b1;
    edges(4); pk(2'd0); chk("50hz_4_edges", last_dout, 8'h01);
    edges(1); pk(2'd0); chk("50hz_5_edges", last_dout, 8'h02);

    // 11:59:59.9 AM -> 12 PM, 12:59:59.9 PM -> 1 PM
    set_time(8'h11, 8'h59, 8'h59, 8'h09);
    edges(5);
    pk(2'd3); chk("noon_hr", last_dout, 8'h92);
    pk(2'd2); chk("noon_min", last_dout, 8'h00);
    pk(2'd1); chk("noon_sec", last_dout, 8'h00);
    pk(2'd0); chk("noon_10ths", last_dout, 8'h00);
    set_time(8'h92, 8'h59, 8'h59, 8'h09);
    edges(5);
    pk(2'd3); chk("one_pm_hr", last_dout, 8'h81);

    // Hour write halts, 10ths write resumes
    wr(1'b0, 2'd3, 8'h05);
    edges(20);
    pk(2'd3); chk("halted_hr", last_dout, 8'h05);
    pk(2'd0); chk("halted_10ths", last_dout, 8'h00);
    chk("halted_flag", {7'd0, halted}, 8'h01);
    wr(1'b0, 2'd0, 8'h03);
    chk("resumed_flag", {7'd0, halted}, 8'h00);
    edges(5);
    pk(2'd0); chk("resumed_10ths", last_dout, 8'h04);
    pk(2'd3); chk("resumed_hr", last_dout, 8'h05);

    // Read latch
    todin = 1'b0;
    set_time(8'h02, 8'h30, 8'h45, 8'h07);
    rd(2'd3); chk("latch_hr_live", last_dout, 8'h02);
    edges(12);
    rd(2'd1); chk("latched_sec", last_dout, 8'h45);
    rd(2'd0); chk("latched_10ths", last_dout, 8'h07);
    rd(2'd1); chk("live_sec", last_dout, 8'h45);
    rd(2'd0); chk("live_10ths", last_dout, 8'h09);

    // Alarm at 01:00:00.2
    do_reset();
    alrm_seen = 0;
    wr(1'b1, 2'd0, 8'h02);
    wr(1'b1, 2'd3, 8'h01);
    todin = 1'b0;
    wr(1'b0, 2'd0, 8'h00);
    edges(11);
    chk("alarm_before_match", 8'(alrm_seen), 8'h00);
    edges(1);
    pk(2'd0); chk("alarm_10ths", last_dout, 8'h02);
    chk("alarm_one_pulse", 8'(alrm_seen), 8'h01);
    pk(2'd0); pk(2'd0);
    edges(6);
    chk("alarm_no_repeat", 8'(alrm_seen), 8'h01);

    // Reset between match and pulse drops the pulse
    do_reset();
    alrm_seen = 0;
    wr(1'b1, 2'd3, 8'h01);
    do_reset();
    pk(2'd0); pk(2'd0); pk(2'd0);
    chk("alrm_dropped_by_reset", 8'(alrm_seen), 8'h00);

    // Chip-dependent 12 o'clock write
    chip = 1'b0;
    wr(1'b0, 2'd3, 8'h12);
    pk(2'd3); chk("mos6526_hr12", last_dout, 8'h92);
    chip = 1'b1;
    wr(1'b0, 2'd3, 8'h12);
    pk(2'd3); chk("mos8521_hr12", last_dout, 8'h12);

    // Write coinciding with a tick
    todin = 1'b1;
    set_time(8'h03, 8'h00, 8'h00, 8'h04);
    edges(4);
    pin_lvl = 1'b1;
    wr(1'b0, 2'd0, 8'h07);
    pin_lvl = 1'b0;
    pk(2'd0); chk("write_beats_tick", last_dout, 8'h07);
    edges(4); pk(2'd0); chk("after_lost_tick_4", last_dout, 8'h07);
    edges(1); pk(2'd0); chk("after_lost_tick_5", last_dout, 8'h08);

    // Randomized traffic against the model, one phase per pin rate
    for (int ph = 0; ph < 2; ph++) begin
      todin = ph[0];
      chip  = 1'b1;
      set_time(bcd(int'($urandom_range(1, 12))) |
               (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00),
               8'h59, 8'h59, bcd(int'($urandom_range(0, 9))));
      for (int i = 0; i < 1500; i++) rand_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
